// File: rtl/ahb_matrix_pkg.sv
// Shared encodings, FSM state types and helpers for the parametrised AHB-Lite matrix.
package ahb_matrix_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;
    typedef enum logic [1:0] {TO_IDLE, TO_ERR1, TO_ERR2} to_state_t;

    function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_matrix_default_slave.sv
// Default slave: answers active transfers to unmapped space with the two-cycle AHB ERROR.
module ahb_matrix_default_slave
    import ahb_matrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);

    ds_state_t state, state_next;
    logic      active;
    logic      take;

    always_comb begin
        active = 1'b0;
        case (HTRANS)
            HTRANS_IDLE, HTRANS_BUSY: active = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            default: active = 1'b0;
        endcase
    end

    assign take = HSEL & active & HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= DS_OK;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        case (state)
            DS_OK: begin
                if (take) state_next = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP      = HRESP_ERROR;
                state_next = take ? DS_ERR1 : DS_OK;
            end
            default: state_next = DS_OK;
        endcase
    end

endmodule

// File: rtl/ahb_lite_matrix_param.sv
// Single-master AHB-Lite interconnect with NSLV base/mask windows and a built-in default slave.
// Define AHB_MATRIX_TIMEOUT_EN to add the stalled-slave timeout (TIMEOUT_CYC, TIMEOUT_FLAG, TIMEOUT_IDX).
module ahb_lite_matrix_param
    import ahb_matrix_pkg::*;
#(
    parameter int NSLV   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NSLV*ADDR_W-1:0] BASE_ADDRS = {NSLV{ADDR_W'(32'h0000_0000)}},
    parameter logic [NSLV*ADDR_W-1:0] ADDR_MASKS = {NSLV{ADDR_W'(32'hF000_0000)}}
`ifdef AHB_MATRIX_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 256
`endif
)
(
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [3:0]             HPROT,
    input  logic                   HMASTLOCK,
    input  logic [DATA_W-1:0]      HWDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [DATA_W-1:0]      HRDATA,
`ifdef AHB_MATRIX_TIMEOUT_EN
    output logic                   TIMEOUT_FLAG,
    output logic [((NSLV > 1) ? $clog2(NSLV) : 1)-1:0] TIMEOUT_IDX,
`endif
    output logic [NSLV-1:0]        HSEL_S,
    output logic [ADDR_W-1:0]      HADDR_S,
    output logic [1:0]             HTRANS_S,
    output logic                   HWRITE_S,
    output logic [2:0]             HSIZE_S,
    output logic [2:0]             HBURST_S,
    output logic [3:0]             HPROT_S,
    output logic                   HMASTLOCK_S,
    output logic [DATA_W-1:0]      HWDATA_S,
    output logic                   HREADY_S,
    input  logic [NSLV-1:0]        HREADYOUT_S,
    input  logic [NSLV-1:0]        HRESP_S,
    input  logic [NSLV*DATA_W-1:0] HRDATA_S
);

    logic [NSLV-1:0]   hit;
    logic [NSLV-1:0]   hsel;
    logic              found;
    logic              def_hit;
    logic [NSLV:0]     dsel;
    logic              def_ready;
    logic              def_resp;
    logic              slv_ready;
    logic              slv_resp;
    logic [DATA_W-1:0] slv_rdata;
    logic              hready_m;
    logic              hresp_m;
    logic [DATA_W-1:0] hrdata_m;

    // Lowest-indexed window wins when windows overlap.
    always_comb begin
        hit   = '0;
        hsel  = '0;
        found = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            hit[i] = ((HADDR & ADDR_MASKS[i*ADDR_W +: ADDR_W]) == BASE_ADDRS[i*ADDR_W +: ADDR_W]);
            if (hit[i] && !found) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign def_hit = ~|hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)      dsel <= '0;
        else if (hready_m) dsel <= {def_hit, hsel};
    end

    ahb_matrix_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (def_hit),
        .HTRANS    (HTRANS),
        .HREADY    (hready_m),
        .HREADYOUT (def_ready),
        .HRESP     (def_resp)
    );

    // An empty dsel (after reset) looks like a completed OKAY transfer.
    always_comb begin
        slv_ready = 1'b1;
        slv_resp  = HRESP_OKAY;
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (dsel[i]) begin
                slv_ready = HREADYOUT_S[i];
                slv_resp  = HRESP_S[i];
                slv_rdata = HRDATA_S[i*DATA_W +: DATA_W];
            end
        end
        if (dsel[NSLV]) begin
            slv_ready = def_ready;
            slv_resp  = def_resp;
        end
    end

`ifdef AHB_MATRIX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    to_state_t        to_state, to_next;
    logic [CNT_W-1:0] stall_cnt;
    logic             stalled;
    logic             fire;
    logic [3:0]       stall_idx;

    assign stalled   = |(dsel[NSLV-1:0] & ~HREADYOUT_S);
    assign fire      = (to_state == TO_IDLE) && stalled && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign stall_idx = onehot_to_idx(16'(dsel[NSLV-1:0]));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_cnt    <= '0;
            to_state     <= TO_IDLE;
            TIMEOUT_FLAG <= 1'b0;
            TIMEOUT_IDX  <= '0;
        end else begin
            to_state <= to_next;
            if (hready_m)
                stall_cnt <= '0;
            else if ((to_state == TO_IDLE) && stalled)
                stall_cnt <= stall_cnt + 1'b1;
            if (fire) begin
                TIMEOUT_FLAG <= 1'b1;
                TIMEOUT_IDX  <= IDX_W'(stall_idx);
            end
        end
    end

    // The second error cycle raises HREADY_S, which abandons the stalled slave's data phase.
    always_comb begin
        to_next  = to_state;
        hready_m = slv_ready;
        hresp_m  = slv_resp;
        hrdata_m = slv_rdata;
        case (to_state)
            TO_IDLE: begin
                if (fire) to_next = TO_ERR1;
            end
            TO_ERR1: begin
                hready_m = 1'b0;
                hresp_m  = HRESP_ERROR;
                hrdata_m = '0;
                to_next  = TO_ERR2;
            end
            TO_ERR2: begin
                hready_m = 1'b1;
                hresp_m  = HRESP_ERROR;
                hrdata_m = '0;
                to_next  = TO_IDLE;
            end
            default: to_next = TO_IDLE;
        endcase
    end
`else
    assign hready_m = slv_ready;
    assign hresp_m  = slv_resp;
    assign hrdata_m = slv_rdata;
`endif

    assign HREADY      = hready_m;
    assign HRESP       = hresp_m;
    assign HRDATA      = hrdata_m;
    assign HREADY_S    = hready_m;
    assign HSEL_S      = hsel;
    assign HADDR_S     = HADDR;
    assign HTRANS_S    = HTRANS;
    assign HWRITE_S    = HWRITE;
    assign HSIZE_S     = HSIZE;
    assign HBURST_S    = HBURST;
    assign HPROT_S     = HPROT;
    assign HMASTLOCK_S = HMASTLOCK;
    assign HWDATA_S    = HWDATA;

endmodule

// File: tb/tb_ahb_lite_matrix_param.sv
// Scoreboard-based bench for ahb_lite_matrix_param with NSLV=8 and overlapping windows on slaves 2 and 5.
// With AHB_MATRIX_TIMEOUT_EN defined the stalled-slave timeout is exercised with TIMEOUT_CYC=8.
module tb_ahb_lite_matrix_param;
    import ahb_matrix_pkg::*;

    localparam int NSLV   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    // Slots listed 7 down to 0; slave 5 (0x20xx_xxxx) overlaps slave 2 (0x2xxx_xxxx).
    localparam logic [NSLV*ADDR_W-1:0] BASES = {32'h7000_0000, 32'h6000_0000, 32'h2000_0000, 32'h5000_0000,
                                                32'h3000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [NSLV*ADDR_W-1:0] MASKS = {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
                                                32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    typedef struct packed {
        logic [31:0] rdata;
        logic        resp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic                   HCLK = 1'b0;
    logic                   HRESETn;
    logic [ADDR_W-1:0]      haddr;
    logic [1:0]             htrans;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [2:0]             hburst;
    logic [3:0]             hprot;
    logic                   hmastlock;
    logic [DATA_W-1:0]      hwdata;
    logic                   HREADY;
    logic                   HRESP;
    logic [DATA_W-1:0]      HRDATA;
    logic [NSLV-1:0]        HSEL_S;
    logic [ADDR_W-1:0]      HADDR_S;
    logic [1:0]             HTRANS_S;
    logic                   HWRITE_S;
    logic [2:0]             HSIZE_S;
    logic [2:0]             HBURST_S;
    logic [3:0]             HPROT_S;
    logic                   HMASTLOCK_S;
    logic [DATA_W-1:0]      HWDATA_S;
    logic                   HREADY_S;
    logic [NSLV-1:0]        hreadyout_s;
    logic [NSLV-1:0]        hresp_s;
    logic [NSLV*DATA_W-1:0] hrdata_s;
`ifdef AHB_MATRIX_TIMEOUT_EN
    logic                   TIMEOUT_FLAG;
    logic [2:0]             TIMEOUT_IDX;
`endif

    always #5 HCLK = ~HCLK;

    ahb_lite_matrix_param #(
        .NSLV       (NSLV),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BASE_ADDRS (BASES),
        .ADDR_MASKS (MASKS)
`ifdef AHB_MATRIX_TIMEOUT_EN
        , .TIMEOUT_CYC (8)
`endif
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .HWRITE      (hwrite),
        .HSIZE       (hsize),
        .HBURST      (hburst),
        .HPROT       (hprot),
        .HMASTLOCK   (hmastlock),
        .HWDATA      (hwdata),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
`ifdef AHB_MATRIX_TIMEOUT_EN
        .TIMEOUT_FLAG(TIMEOUT_FLAG),
        .TIMEOUT_IDX (TIMEOUT_IDX),
`endif
        .HSEL_S      (HSEL_S),
        .HADDR_S     (HADDR_S),
        .HTRANS_S    (HTRANS_S),
        .HWRITE_S    (HWRITE_S),
        .HSIZE_S     (HSIZE_S),
        .HBURST_S    (HBURST_S),
        .HPROT_S     (HPROT_S),
        .HMASTLOCK_S (HMASTLOCK_S),
        .HWDATA_S    (HWDATA_S),
        .HREADY_S    (HREADY_S),
        .HREADYOUT_S (hreadyout_s),
        .HRESP_S     (hresp_s),
        .HRDATA_S    (hrdata_s)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic slaves_ready();
        hreadyout_s = '1;
        hresp_s     = '0;
    endtask

    // Models slave idx for one data phase (waits stall cycles) and returns what the master saw on completion.
    task automatic run_data_phase(input int idx, input int waits, input logic [31:0] rdata, input logic resp,
                                  output int stalls, output logic [31:0] got_data, output logic got_resp,
                                  output logic got_ok);
        stalls   = 0;
        got_ok   = 1'b0;
        got_data = '0;
        got_resp = 1'b0;
        for (int c = 0; c < 40; c++) begin
            hreadyout_s[idx]        = (c >= waits);
            hresp_s[idx]            = (c >= waits) ? resp : 1'b0;
            hrdata_s[idx*32 +: 32]  = (c >= waits) ? rdata : 32'h0;
            @(negedge HCLK);
            if (HREADY === 1'b1) begin
                got_data = HRDATA;
                got_resp = HRESP;
                got_ok   = 1'b1;
                break;
            end
            stalls++;
            tick();
        end
    endtask

    task automatic test_reset();
        HRESETn   = 1'b0;
        idle_bus();
        slaves_ready();
        hsize     = 3'b010;
        hburst    = 3'b000;
        hprot     = 4'b0011;
        hmastlock = 1'b0;
        hwdata    = '0;
        hrdata_s  = {NSLV{32'hA5A5_5A5A}};
        #12;
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_hready: got %b expected 1", HREADY); end
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hresp: got %b expected 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hrdata: got %h expected 0", HRDATA); end
        n_checks++; if (HREADY_S !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_hready_s: got %b expected 1", HREADY_S); end
`ifdef AHB_MATRIX_TIMEOUT_EN
        n_checks++; if (TIMEOUT_FLAG !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout_flag: got %b expected 0", TIMEOUT_FLAG); end
`endif
        haddr = 32'h4000_0000;
        #1;
        n_checks++; if (HSEL_S !== 8'h02) begin n_fail++; $display("[TB] FAIL reset_idle_decode: got %h expected 02", HSEL_S); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        idle_bus();
    endtask

    task automatic test_read_wait();
        exp_t        e;
        int          stalls;
        logic [31:0] d;
        logic        r;
        logic        ok;
        haddr  = 32'h4000_0010;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b0;
        sb.push_back('{rdata: 32'hDEAD_BEEF, resp: HRESP_OKAY});
        @(negedge HCLK);
        n_checks++; if (HSEL_S !== 8'h02) begin n_fail++; $display("[TB] FAIL read_wait_hsel: got %h expected 02", HSEL_S); end
        tick();
        idle_bus();
        run_data_phase(1, 2, 32'hDEAD_BEEF, HRESP_OKAY, stalls, d, r, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL read_wait_complete: got %b expected 1", ok); end
        n_checks++; if (stalls != 2) begin n_fail++; $display("[TB] FAIL read_wait_stalls: got %0d expected 2", stalls); end
        e = sb.pop_front();
        n_checks++; if (d !== e.rdata) begin n_fail++; $display("[TB] FAIL read_wait_hrdata: got %h expected %h", d, e.rdata); end
        n_checks++; if (r !== e.resp) begin n_fail++; $display("[TB] FAIL read_wait_hresp: got %b expected %b", r, e.resp); end
        tick();
        slaves_ready();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        hrdata_s[0*32 +: 32] = 32'h1111_0000;
        hrdata_s[3*32 +: 32] = 32'h3333_0000;
        haddr  = 32'h0000_0100;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        sb.push_back('{rdata: 32'h1111_0000, resp: HRESP_OKAY});
        @(negedge HCLK);
        n_checks++; if (HSEL_S !== 8'h01) begin n_fail++; $display("[TB] FAIL b2b_hsel0: got %h expected 01", HSEL_S); end
        tick();
        haddr  = 32'h3000_0040;
        hwdata = 32'hCAFE_0000;
        sb.push_back('{rdata: 32'h3333_0000, resp: HRESP_OKAY});
        @(negedge HCLK);
        n_checks++; if (HSEL_S !== 8'h08) begin n_fail++; $display("[TB] FAIL b2b_hsel3: got %h expected 08", HSEL_S); end
        n_checks++; if (HADDR_S !== 32'h3000_0040) begin n_fail++; $display("[TB] FAIL b2b_haddr_s: got %h expected 30000040", HADDR_S); end
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_hready0: got %b expected 1", HREADY); end
        e = sb.pop_front();
        n_checks++; if (HRDATA !== e.rdata) begin n_fail++; $display("[TB] FAIL b2b_mux0: got %h expected %h", HRDATA, e.rdata); end
        n_checks++; if (HWDATA_S !== 32'hCAFE_0000) begin n_fail++; $display("[TB] FAIL b2b_hwdata0: got %h expected cafe0000", HWDATA_S); end
        tick();
        idle_bus();
        hwdata = 32'hCAFE_0003;
        @(negedge HCLK);
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_hready3: got %b expected 1", HREADY); end
        e = sb.pop_front();
        n_checks++; if (HRDATA !== e.rdata) begin n_fail++; $display("[TB] FAIL b2b_mux3: got %h expected %h", HRDATA, e.rdata); end
        n_checks++; if (HRESP !== e.resp) begin n_fail++; $display("[TB] FAIL b2b_hresp3: got %b expected %b", HRESP, e.resp); end
        tick();
    endtask

    task automatic test_unmapped();
        exp_t e;
        haddr  = 32'hE000_0000;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b0;
        sb.push_back('{rdata: 32'h0, resp: HRESP_ERROR});
        @(negedge HCLK);
        n_checks++; if (HSEL_S !== 8'h00) begin n_fail++; $display("[TB] FAIL unmapped_hsel: got %h expected 00", HSEL_S); end
        tick();
        htrans = HTRANS_IDLE;
        @(negedge HCLK);
        n_checks++; if (HREADY !== 1'b0) begin n_fail++; $display("[TB] FAIL unmapped_err1_hready: got %b expected 0", HREADY); end
        n_checks++; if (HRESP !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_err1_hresp: got %b expected 1", HRESP); end
        tick();
        @(negedge HCLK);
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_err2_hready: got %b expected 1", HREADY); end
        e = sb.pop_front();
        n_checks++; if (HRESP !== e.resp) begin n_fail++; $display("[TB] FAIL unmapped_err2_hresp: got %b expected %b", HRESP, e.resp); end
        n_checks++; if (HRDATA !== e.rdata) begin n_fail++; $display("[TB] FAIL unmapped_hrdata: got %h expected %h", HRDATA, e.rdata); end
        tick();
        @(negedge HCLK);
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_idle_hready: got %b expected 1", HREADY); end
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("[TB] FAIL unmapped_idle_hresp: got %b expected 0", HRESP); end
        tick();
        idle_bus();
    endtask

    task automatic test_overlap();
        exp_t        e;
        int          stalls;
        logic [31:0] d;
        logic        r;
        logic        ok;
        hrdata_s[2*32 +: 32] = 32'h2222_2222;
        hrdata_s[5*32 +: 32] = 32'h5555_5555;
        haddr  = 32'h20F0_0000;
        #1;
        n_checks++; if (HSEL_S !== 8'h04) begin n_fail++; $display("[TB] FAIL overlap_slave2_only: got %h expected 04", HSEL_S); end
        haddr  = 32'h2000_0000;
        htrans = HTRANS_NONSEQ;
        sb.push_back('{rdata: 32'h2222_2222, resp: HRESP_OKAY});
        @(negedge HCLK);
        n_checks++; if (HSEL_S !== 8'h04) begin n_fail++; $display("[TB] FAIL overlap_hsel: got %h expected 04", HSEL_S); end
        tick();
        idle_bus();
        run_data_phase(2, 0, 32'h2222_2222, HRESP_OKAY, stalls, d, r, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL overlap_complete: got %b expected 1", ok); end
        e = sb.pop_front();
        n_checks++; if (d !== e.rdata) begin n_fail++; $display("[TB] FAIL overlap_hrdata: got %h expected %h", d, e.rdata); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        haddr  = 32'h4000_0020;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b0;
        tick();
        idle_bus();
        hreadyout_s[1]       = 1'b0;
        hresp_s[1]           = 1'b1;
        hrdata_s[1*32 +: 32] = 32'hBAD0_BAD0;
        @(negedge HCLK);
        n_checks++; if (HREADY !== 1'b0) begin n_fail++; $display("[TB] FAIL midwait_hready: got %b expected 0", HREADY); end
        n_checks++; if (HRESP !== 1'b1) begin n_fail++; $display("[TB] FAIL midwait_resp_passthru: got %b expected 1", HRESP); end
        #2;
        HRESETn = 1'b0;
        #1;
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_hready: got %b expected 1", HREADY); end
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_hresp: got %b expected 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_hrdata: got %h expected 0", HRDATA); end
        slaves_ready();
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
    endtask

`ifdef AHB_MATRIX_TIMEOUT_EN
    task automatic test_timeout();
        int   stalls;
        logic done;
        haddr  = 32'h2000_0000;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b0;
        @(negedge HCLK);
        n_checks++; if (TIMEOUT_FLAG !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_flag_pre: got %b expected 0", TIMEOUT_FLAG); end
        tick();
        idle_bus();
        hreadyout_s[2] = 1'b0;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge HCLK);
            if (HREADY === 1'b0 && HRESP === 1'b0) begin
                stalls++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        n_checks++; if (stalls != 8) begin n_fail++; $display("[TB] FAIL timeout_stalls: got %0d expected 8", stalls); end
        n_checks++; if (HREADY !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_err1_hready: got %b expected 0", HREADY); end
        n_checks++; if (HRESP !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err1_hresp: got %b expected 1", HRESP); end
        n_checks++; if (HREADY_S !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_err1_hready_s: got %b expected 0", HREADY_S); end
        tick();
        @(negedge HCLK);
        n_checks++; if (HREADY !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err2_hready: got %b expected 1", HREADY); end
        n_checks++; if (HRESP !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err2_hresp: got %b expected 1", HRESP); end
        n_checks++; if (HREADY_S !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_err2_hready_s: got %b expected 1", HREADY_S); end
        n_checks++; if (TIMEOUT_FLAG !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_flag: got %b expected 1", TIMEOUT_FLAG); end
        n_checks++; if (TIMEOUT_IDX !== 3'd2) begin n_fail++; $display("[TB] FAIL timeout_idx: got %0d expected 2", TIMEOUT_IDX); end
        tick();
        slaves_ready();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected completion within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_read_wait();
        test_back_to_back();
        test_unmapped();
        test_overlap();
        test_reset_mid_wait();
`ifdef AHB_MATRIX_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_drained: got %0d expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_matrix_param.md
Name: ahb_lite_matrix_param

Overview:
Parametrised single-master AHB-Lite interconnect that succeeds the fixed 8-port interconnect.
- Decodes HADDR against NSLV programmable base/mask windows.
- Registers the data-phase slave select and multiplexes HREADY/HRESP/HRDATA back to the master.
- Adds a built-in default slave that returns the two-cycle AHB ERROR response for unmapped accesses.
- Sits between the core bus port and all peripherals in the SoC top.

Parameters:
NSLV, 8, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
BASE_ADDRS, {NSLV{32'h0}}, flattened NSLV*ADDR_W window bases; slot i at [i*ADDR_W +: ADDR_W]
ADDR_MASKS, {NSLV{32'hF000_0000}}, flattened NSLV*ADDR_W decode masks
TIMEOUT_CYC, 256, stall limit for the optional timeout feature (>=2)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  ADDR_W  master address
HTRANS  in  2  master transfer type
HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK, HWDATA[DATA_W]  in  -  master control and write data
HREADY  out  1  muxed ready to master
HRESP  out  1  muxed response to master
HRDATA  out  DATA_W  muxed read data
HSEL_S  out  NSLV  per-slave select
HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HMASTLOCK_S, HWDATA_S  out  -  broadcast copies of the master signals
HREADY_S  out  1  broadcast HREADY
HREADYOUT_S  in  NSLV  per-slave ready
HRESP_S  in  NSLV  per-slave response
HRDATA_S  in  NSLV*DATA_W  flattened slave read data

Behaviour:
- Decode (combinational): hit_i = ((HADDR & MASK_i) == BASE_i). Lowest index wins on overlap. HSEL_S[i] = hit_i and not any lower hit. HSEL is independent of HTRANS; slaves qualify with HTRANS[1] & HREADY_S.
- Default selected (def_hit) when no window hits.
- Data-phase select register dsel[NSLV:0], one-hot, bit NSLV = default slave.
  - Loads {def_hit, HSEL_S} on each rising HCLK with HREADY=1.
  - Holds while HREADY=0.
  - Reset value 0 (nothing selected).
- Master return path:
  - dsel==0: HREADY=1, HRESP=0, HRDATA=0.
  - dsel[i]: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S slot i.
  - dsel[NSLV]: outputs taken from the default slave.
- Default slave FSM, states DS_OK, DS_ERR1, DS_ERR2:
  - DS_OK: drives HREADY=1, HRESP=0. Moves to DS_ERR1 when def_hit & HTRANS[1] & HREADY.
  - DS_ERR1: drives HREADY=0, HRESP=1. Always moves to DS_ERR2.
  - DS_ERR2: drives HREADY=1, HRESP=1. Moves to DS_ERR1 if a new unmapped NONSEQ/SEQ is sampled, else DS_OK.
  - IDLE/BUSY to an unmapped address: zero-wait OKAY.
  - Default read data is 0.
- Latency: zero added cycles. Decode and return mux are combinational; the only register is on the address-to-data phase boundary.
- Reset mid-transfer: dsel and FSM clear immediately and asynchronously; HREADY=1, HRESP=0 at once.
- Back-to-back transfers to different slaves: dsel switches on the same edge that completes the previous data phase; no bubble.
- Slave HRESP=1 with HREADYOUT=0 passes through unmodified.

Optional Feature:
- Macro AHB_MATRIX_TIMEOUT_EN.
- Enabled:
  - A $clog2(TIMEOUT_CYC+1)-bit counter counts consecutive cycles with dsel[i]=1 and HREADYOUT_S[i]=0. It clears when HREADY=1.
  - On reaching TIMEOUT_CYC-1, the interconnect overrides the stalled slave and issues the two-cycle ERROR to the master (HREADY 0/HRESP 1, then HREADY 1/HRESP 1). HREADY_S goes to 1 in the second cycle, which abandons the slave's data phase.
  - Extra output TIMEOUT_FLAG (1 bit, sticky, reset 0) sets on timeout.
  - Extra output TIMEOUT_IDX ($clog2(NSLV) bits, reset 0) holds the slave index captured at the timeout.
- Disabled: no counter and no extra ports; stalls are unbounded.

Decomposition:
- Package ahb_matrix_pkg holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HRESP_OKAY/HRESP_ERROR
  - default-slave state enum
  - helper function for one-hot to index
- One sub-module, ahb_matrix_default_slave, containing the error FSM (inputs HSEL, HTRANS, HREADY; outputs HREADYOUT, HRESP).

Test Plan:
- Reset with HRESETn=0 mid-wait-state -> HREADY=1, HRESP=0, HRDATA=0 immediately, with dsel cleared.
- NSLV=4, BASE1=0x4000_0000, MASK=0xF000_0000, read 0x4000_0010, slave1 inserts 2 waits and returns 0xDEADBEEF -> HREADY low for 2 cycles, then HRDATA=0xDEADBEEF, HRESP=0.
- Back-to-back NONSEQ writes to slave0 then slave3 with zero waits -> correct HSEL_S one-hot each cycle; no extra cycles.
- NONSEQ read to unmapped 0xE000_0000 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1, HRDATA=0; an IDLE to the same address gives an OKAY response.
- Overlapping windows for slaves 2 and 5 both hitting 0x2000_0000 -> only HSEL_S[2] is asserted.
- With AHB_MATRIX_TIMEOUT_EN and TIMEOUT_CYC=8, slave2 holds HREADYOUT=0 forever -> ERROR pair issued after 8 stall cycles, TIMEOUT_FLAG=1, TIMEOUT_IDX=2.
